// File: rtl/mips_ctrl.sv
// Multicycle control unit for the 8-bit MIPS datapath: one state per clock, Moore outputs.
// Define MIPS_CTRL_ADDI_EN to add the ADDIEX/ADDIWR states that decode addi (op 001000).
module mips_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic       memtoreg,
  output logic       regdst,
  output logic       iord,
  output logic       regwrite,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [3:0] irwrite,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12
`ifdef MIPS_CTRL_ADDI_EN
    , S_ADDIEX = 4'd13,
    S_ADDIWR  = 4'd14
`endif
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     r_state;
  state_t     w_next;

  logic       w_memread;
  logic       w_memwrite;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [2:0] w_alucontrol;
  logic       w_memtoreg;
  logic       w_regdst;
  logic       w_iord;
  logic       w_regwrite;
  logic [1:0] w_pcsrc;
  logic       w_pcwrite;
  logic       w_branch;
  logic [3:0] w_irwrite;
  logic       w_instrDone;
  logic       w_illegal;
  logic [2:0] w_functAlu;
  logic       w_functOk;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH1;
    else       r_state <= w_next;
  end

  always_comb begin
    w_functOk  = 1'b1;
    w_functAlu = ALU_ADD;
    case (funct)
      6'b100000: w_functAlu = ALU_ADD;
      6'b100010: w_functAlu = ALU_SUB;
      6'b100100: w_functAlu = ALU_AND;
      6'b100101: w_functAlu = ALU_OR;
      6'b101010: w_functAlu = ALU_SLT;
      default:   w_functOk  = 1'b0;
    endcase
  end

  always_comb begin
    w_next       = S_FETCH1;
    w_memread    = 1'b0;
    w_memwrite   = 1'b0;
    w_alusrca    = 1'b0;
    w_alusrcb    = 2'b00;
    w_alucontrol = ALU_ADD;
    w_memtoreg   = 1'b0;
    w_regdst     = 1'b0;
    w_iord       = 1'b0;
    w_regwrite   = 1'b0;
    w_pcsrc      = 2'b00;
    w_pcwrite    = 1'b0;
    w_branch     = 1'b0;
    w_irwrite    = 4'b0000;
    w_instrDone  = 1'b0;
    w_illegal    = 1'b0;

    case (r_state)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        w_memread = 1'b1;
        w_alusrcb = 2'b01;
        w_pcwrite = 1'b1;
        case (r_state)
          S_FETCH1: begin w_irwrite = 4'b0001; w_next = S_FETCH2; end
          S_FETCH2: begin w_irwrite = 4'b0010; w_next = S_FETCH3; end
          S_FETCH3: begin w_irwrite = 4'b0100; w_next = S_FETCH4; end
          default:  begin w_irwrite = 4'b1000; w_next = S_DECODE; end
        endcase
      end
      S_DECODE: begin
        w_alusrcb = 2'b11;
        case (op)
          6'b100000, 6'b101000: w_next = S_MEMADR;
          6'b000000:            w_next = S_RTYPEEX;
          6'b000100:            w_next = S_BEQEX;
          6'b000010:            w_next = S_JEX;
`ifdef MIPS_CTRL_ADDI_EN
          6'b001000:            w_next = S_ADDIEX;
`endif
          default: begin
            w_next    = S_FETCH1;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = (op == 6'b100000) ? S_LBRD : S_SBWR;
      end
      S_LBRD: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
        w_next    = S_LBWR;
      end
      S_LBWR: begin
        w_regwrite  = 1'b1;
        w_memtoreg  = 1'b1;
        w_instrDone = 1'b1;
      end
      S_SBWR: begin
        w_memwrite  = 1'b1;
        w_iord      = 1'b1;
        w_instrDone = 1'b1;
      end
      S_RTYPEEX: begin
        w_alusrca    = 1'b1;
        w_alucontrol = w_functAlu;
        w_illegal    = ~w_functOk;
        w_next       = S_RTYPEWR;
      end
      // An undecodable funct still retires, but must not corrupt the register file.
      S_RTYPEWR: begin
        w_regdst    = 1'b1;
        w_regwrite  = w_functOk;
        w_instrDone = 1'b1;
      end
      S_BEQEX: begin
        w_alusrca    = 1'b1;
        w_alucontrol = ALU_SUB;
        w_pcsrc      = 2'b01;
        w_branch     = 1'b1;
        w_instrDone  = 1'b1;
      end
      S_JEX: begin
        w_pcsrc     = 2'b10;
        w_pcwrite   = 1'b1;
        w_instrDone = 1'b1;
      end
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = S_ADDIWR;
      end
      S_ADDIWR: begin
        w_regwrite  = 1'b1;
        w_instrDone = 1'b1;
      end
`endif
      default: w_next = S_FETCH1;
    endcase
  end

  // Reset masks every strobe so an aborted instruction cannot write memory, registers or PC.
  always_comb begin
    memread    = w_memread;
    memwrite   = w_memwrite;
    alusrca    = w_alusrca;
    alusrcb    = w_alusrcb;
    alucontrol = w_alucontrol;
    memtoreg   = w_memtoreg;
    regdst     = w_regdst;
    iord       = w_iord;
    regwrite   = w_regwrite;
    pcsrc      = w_pcsrc;
    pcen       = w_pcwrite | (w_branch & zero);
    irwrite    = w_irwrite;
    instr_done = w_instrDone;
    illegal    = w_illegal;
    if (reset) begin
      memread    = 1'b0;
      memwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      alucontrol = 3'b000;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      iord       = 1'b0;
      regwrite   = 1'b0;
      pcsrc      = 2'b00;
      pcen       = 1'b0;
      irwrite    = 4'b0000;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_ctrl.sv
// Scoreboard bench for mips_ctrl: stimulus queues the expected output vector for each cycle,
// a negedge monitor pops and compares. Covers ADDI with or without MIPS_CTRL_ADDI_EN.
module tb_mips_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       memread, memwrite, alusrca, memtoreg, regdst, iord, regwrite, pcen;
  logic       instr_done, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] irwrite;

  always #5 clk = ~clk;

  mips_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memread(memread), .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .alucontrol(alucontrol), .memtoreg(memtoreg), .regdst(regdst), .iord(iord),
    .regwrite(regwrite), .pcsrc(pcsrc), .pcen(pcen), .irwrite(irwrite),
    .instr_done(instr_done), .illegal(illegal)
  );

  typedef struct {
    string       name;
    logic [20:0] exp;
  } exp_t;

  exp_t        scoreQ[$];
  exp_t        monEntry;
  int          compared = 0;
  int          mismatched = 0;
  logic [20:0] actual;

  // Field order: memread memwrite alusrca alusrcb alucontrol memtoreg regdst iord regwrite pcsrc pcen irwrite done illegal
  assign actual = {memread, memwrite, alusrca, alusrcb, alucontrol, memtoreg, regdst, iord,
                   regwrite, pcsrc, pcen, irwrite, instr_done, illegal};

  function automatic logic [20:0] vec(input logic mr, input logic mw, input logic asa,
                                      input logic [1:0] asb, input logic [2:0] ac,
                                      input logic mtr, input logic rd, input logic iod,
                                      input logic rw, input logic [1:0] ps, input logic pe,
                                      input logic [3:0] irw, input logic dn, input logic il);
    return {mr, mw, asa, asb, ac, mtr, rd, iod, rw, ps, pe, irw, dn, il};
  endfunction

  localparam logic [20:0] ALLZERO = 21'd0;

  always @(negedge clk) begin
    if (scoreQ.size() > 0) begin
      monEntry = scoreQ.pop_front();
      compared++;
      if (actual !== monEntry.exp) begin
        mismatched++;
        $display("[TB] FAIL %s: got %b required %b", monEntry.name, actual, monEntry.exp);
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic [5:0] o, input logic [5:0] f,
                               input logic z, input logic [20:0] e, input string nm);
    exp_t ent;
    @(posedge clk);
    #1;
    reset = rst;
    op    = o;
    funct = f;
    zero  = z;
    ent.name = nm;
    ent.exp  = e;
    scoreQ.push_back(ent);
  endtask

  function automatic logic [20:0] fetchVec(input int n);
    logic [3:0] irw;
    irw = 4'b0001 << n;
    return vec(1, 0, 0, 2'b01, 3'b000, 0, 0, 0, 0, 2'b00, 1, irw, 0, 0);
  endfunction

  function automatic logic [20:0] decodeVec(input logic il);
    return vec(0, 0, 0, 2'b11, 3'b000, 0, 0, 0, 0, 2'b00, 0, 4'b0000, 0, il);
  endfunction

  task automatic fetchCycles(input logic [5:0] o, input logic [5:0] f, input string tag);
    for (int n = 0; n < 4; n++)
      applyStimulus(0, o, f, 0, fetchVec(n), $sformatf("%s_fetch%0d", tag, n + 1));
  endtask

  task automatic runRtype(input logic [5:0] f, input logic [2:0] ac, input logic ok);
    string tag;
    tag = $sformatf("rtype_%b", f);
    fetchCycles(6'b000000, f, tag);
    applyStimulus(0, 6'b000000, f, 0, decodeVec(0), {tag, "_decode"});
    applyStimulus(0, 6'b000000, f, 0,
                  vec(0, 0, 1, 2'b00, ac, 0, 0, 0, 0, 2'b00, 0, 4'b0000, 0, ~ok),
                  {tag, "_ex"});
    applyStimulus(0, 6'b000000, f, 0,
                  vec(0, 0, 0, 2'b00, 3'b000, 0, 1, 0, ok, 2'b00, 0, 4'b0000, 1, 0),
                  {tag, "_wr"});
  endtask

  task automatic runBeq(input logic z);
    string tag;
    tag = $sformatf("beq_z%0d", z);
    fetchCycles(6'b000100, 6'd0, tag);
    applyStimulus(0, 6'b000100, 6'd0, 1, decodeVec(0), {tag, "_decode"});
    applyStimulus(0, 6'b000100, 6'd0, z,
                  vec(0, 0, 1, 2'b00, 3'b110, 0, 0, 0, 0, 2'b01, z, 4'b0000, 1, 0),
                  {tag, "_ex"});
  endtask

  task automatic checkOutput();
    int budget;
    budget = 10;
    while (scoreQ.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(negedge clk);
    #1;
    compared++;
    if (scoreQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending required 0", scoreQ.size());
    end
  endtask

  initial begin
    repeat (3) applyStimulus(1, 6'd0, 6'd0, 0, ALLZERO, "reset_hold");

    runRtype(6'b100010, 3'b110, 1);
    runRtype(6'b100100, 3'b001, 1);
    runRtype(6'b100101, 3'b010, 1);
    runRtype(6'b101010, 3'b111, 1);
    runRtype(6'b100000, 3'b000, 1);
    runRtype(6'b111111, 3'b000, 0);

    runBeq(1);
    runBeq(0);

    fetchCycles(6'b100000, 6'd0, "lb");
    applyStimulus(0, 6'b100000, 6'd0, 0, decodeVec(0), "lb_decode");
    applyStimulus(0, 6'b100000, 6'd0, 0,
                  vec(0, 0, 1, 2'b10, 3'b000, 0, 0, 0, 0, 2'b00, 0, 4'b0000, 0, 0), "lb_memadr");
    applyStimulus(0, 6'b100000, 6'd0, 0,
                  vec(1, 0, 0, 2'b00, 3'b000, 0, 0, 1, 0, 2'b00, 0, 4'b0000, 0, 0), "lb_rd");
    applyStimulus(0, 6'b100000, 6'd0, 0,
                  vec(0, 0, 0, 2'b00, 3'b000, 1, 0, 0, 1, 2'b00, 0, 4'b0000, 1, 0), "lb_wr");

    fetchCycles(6'b101000, 6'd0, "sb");
    applyStimulus(0, 6'b101000, 6'd0, 0, decodeVec(0), "sb_decode");
    applyStimulus(0, 6'b101000, 6'd0, 0,
                  vec(0, 0, 1, 2'b10, 3'b000, 0, 0, 0, 0, 2'b00, 0, 4'b0000, 0, 0), "sb_memadr");
    applyStimulus(0, 6'b101000, 6'd0, 0,
                  vec(0, 1, 0, 2'b00, 3'b000, 0, 0, 1, 0, 2'b00, 0, 4'b0000, 1, 0), "sb_wr");

    fetchCycles(6'b000010, 6'd0, "j");
    applyStimulus(0, 6'b000010, 6'd0, 0, decodeVec(0), "j_decode");
    applyStimulus(0, 6'b000010, 6'd0, 0,
                  vec(0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 2'b10, 1, 4'b0000, 1, 0), "j_ex");

    fetchCycles(6'b111111, 6'd0, "badop");
    applyStimulus(0, 6'b111111, 6'd0, 0, decodeVec(1), "badop_decode");

    fetchCycles(6'b001000, 6'd0, "addi");
`ifdef MIPS_CTRL_ADDI_EN
    applyStimulus(0, 6'b001000, 6'd0, 0, decodeVec(0), "addi_decode");
    applyStimulus(0, 6'b001000, 6'd0, 0,
                  vec(0, 0, 1, 2'b10, 3'b000, 0, 0, 0, 0, 2'b00, 0, 4'b0000, 0, 0), "addi_ex");
    applyStimulus(0, 6'b001000, 6'd0, 0,
                  vec(0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 1, 2'b00, 0, 4'b0000, 1, 0), "addi_wr");
`else
    applyStimulus(0, 6'b001000, 6'd0, 0, decodeVec(1), "addi_illegal_decode");
`endif

    applyStimulus(0, 6'b000010, 6'd0, 0, fetchVec(0), "abort_fetch1");
    applyStimulus(0, 6'b000010, 6'd0, 0, fetchVec(1), "abort_fetch2");
    applyStimulus(1, 6'b000010, 6'd0, 1, ALLZERO, "abort_reset_in_fetch3");
    fetchCycles(6'b000010, 6'd0, "restart");
    applyStimulus(0, 6'b000010, 6'd0, 0, decodeVec(0), "restart_decode");
    applyStimulus(0, 6'b000010, 6'd0, 0,
                  vec(0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 2'b10, 1, 4'b0000, 1, 0), "restart_j_ex");
    applyStimulus(0, 6'd0, 6'd0, 0, fetchVec(0), "post_done_fetch1");

    checkOutput();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
